sync_fifo: RTL and testbench

Single-clock synchronous FIFO with parameterised width and depth. It buffers data words between a producer and a consumer in the same clock domain and exposes full/empty status for flow control. Read data is registered and appears one cycle after an accepted read. The block is a generic datapath buffer that any same-clock pipeline stage can instantiate.

---
 rtl/sync_fifo_if.sv | 45 ++++
 rtl/sync_fifo.sv | 99 +++++++++
 tb/tb_sync_fifo.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo (write side, read side, status).
// Pure wiring: no state, no latency of its own.
// FIFO_ERR_FLAGS_EN adds the overflow/underflow status signals.
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    // User side: issues requests and watches status.
    modport master (
        output wr_en,
        output rd_en,
        output din,
        input  dout,
        input  full,
`ifdef FIFO_ERR_FLAGS_EN
        input  overflow,
        input  underflow,
`endif
        input  empty
    );

    // FIFO side: accepts requests and drives status.
    modport slave (
        input  wr_en,
        input  rd_en,
        input  din,
        output dout,
        output full,
`ifdef FIFO_ERR_FLAGS_EN
        output overflow,
        output underflow,
`endif
        output empty
    );
endinterface

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO, DATA_WIDTH x DEPTH (any DEPTH >= 2); optional FIFO_ERR_FLAGS_EN adds overflow/underflow pulses.
// Latency: a write is readable on the next edge; dout is registered and valid right after the edge that accepts the read.
// Backpressure: writes while full are dropped unless a read is accepted on the same edge; reads while empty are ignored.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic          clk,
    input  logic          rst_,
    sync_fifo_if.slave    fifo
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic full_w;
    logic empty_w;
    logic rd_ok;
    logic wr_ok;

    // Status is decoded from the registered count only, so no input-to-flag path.
    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign rd_ok = fifo.rd_en && !empty_w;
    assign wr_ok = fifo.wr_en && (!full_w || rd_ok);

    // Next-state for pointers, occupancy and read data.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        if (wr_ok) begin
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        end
        if (rd_ok) begin
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
            dout_d = mem[rptr_q];
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state register; reset wins over any request on the same edge.
    always_ff @(posedge clk) begin
        if (rst_) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // Storage array has no reset; writes are suppressed on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst_ && wr_ok) begin
            mem[wptr_q] <= fifo.din;
        end
    end

    assign fifo.dout  = dout_q;
    assign fifo.full  = full_w;
    assign fifo.empty = empty_w;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // One-cycle pulses flagging a request that was dropped on the previous edge.
    always_ff @(posedge clk) begin
        if (rst_) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= fifo.wr_en && !wr_ok;
            underflow_q <= fifo.rd_en && !rd_ok;
        end
    end

    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at default parameters (8 x 16).
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
// Expected values are hand-derived constants and loop indices.
module tb_sync_fifo;
    logic clk;
    logic rst_;
    int   n_chk;
    int   n_pass;

    sync_fifo_if #(.DATA_WIDTH(8)) bus ();

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .fifo (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given requests; returns 1 ns after the edge with requests dropped.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_      = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.din   = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ = 1'b0;

        // Reset state
        check("rst_empty", bus.empty, 1);
        check("rst_full",  bus.full,  0);
        check("rst_dout",  bus.dout,  0);
`ifdef FIFO_ERR_FLAGS_EN
        check("rst_ovf", bus.overflow,  0);
        check("rst_unf", bus.underflow, 0);
`endif

        // Fill 0..15
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            check("fill_empty", bus.empty, 0);
            check("fill_full",  bus.full, (i == 15) ? 1 : 0);
        end
        check("fill_dout_hold", bus.dout, 0);

        // Write 16 while full: dropped
        step(1'b1, 1'b0, 8'd16);
        check("ovf_full", bus.full, 1);
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf_pulse", bus.overflow, 1);
        step(1'b0, 1'b0, 8'd0);
        check("ovf_clear", bus.overflow, 0);
`endif

        // Drain: exactly 0..15
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check("drain_dout",  bus.dout, i);
            check("drain_full",  bus.full, 0);
            check("drain_empty", bus.empty, (i == 15) ? 1 : 0);
        end

        // 17 reads on empty: dout holds 15
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check("unf_dout",  bus.dout, 15);
            check("unf_empty", bus.empty, 1);
`ifdef FIFO_ERR_FLAGS_EN
            check("unf_pulse", bus.underflow, 1);
`endif
        end
        // A write right after must bring the FIFO to exactly one entry.
        step(1'b1, 1'b1, 8'hA5);
        check("rw_empty_empty", bus.empty, 0);
        check("rw_empty_full",  bus.full,  0);
        check("rw_empty_dout",  bus.dout,  15);
        step(1'b0, 1'b1, 8'd0);
        check("rw_empty_rd",    bus.dout,  8'hA5);
        check("rw_empty_after", bus.empty, 1);

        // Refill 0..15, then simultaneous read+write while full
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
        check("refill_full", bus.full, 1);
        step(1'b1, 1'b1, 8'h77);
        check("rw_full_dout", bus.dout, 0);
        check("rw_full_full", bus.full, 1);
        // Partial: one read, then simultaneous read+write keeps occupancy at 15
        step(1'b0, 1'b1, 8'd0);
        check("part_rd", bus.dout, 1);
        step(1'b1, 1'b1, 8'h88);
        check("rw_part_dout", bus.dout, 2);
        check("rw_part_full", bus.full, 0);
        // Remaining order: 3..15, 0x77, 0x88
        for (int i = 3; i < 16; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check("rw_drain", bus.dout, i);
        end
        step(1'b0, 1'b1, 8'd0);
        check("rw_drain_77", bus.dout, 8'h77);
        check("rw_drain_77_empty", bus.empty, 0);
        step(1'b0, 1'b1, 8'd0);
        check("rw_drain_88", bus.dout, 8'h88);
        check("rw_drain_88_empty", bus.empty, 1);

        // Reset mid-operation; a write on the reset edge is ignored
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        step(1'b0, 1'b1, 8'd0);
        check("pre_rst_dout", bus.dout, 8'h11);
        rst_ = 1'b1;
        step(1'b1, 1'b1, 8'h44);
        rst_ = 1'b0;
        check("mid_rst_empty", bus.empty, 1);
        check("mid_rst_full",  bus.full,  0);
        check("mid_rst_dout",  bus.dout,  0);
        step(1'b1, 1'b0, 8'h55);
        check("post_rst_wr_empty", bus.empty, 0);
        step(1'b0, 1'b1, 8'd0);
        check("post_rst_rd",    bus.dout,  8'h55);
        check("post_rst_empty", bus.empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
